// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state, hazard
// cause, and the per-stage write-enable/flush bundle.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pctrl_state_t;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_DSTALL   = 3'd1,
    HZ_REDIRECT = 3'd2,
    HZ_LOADUSE  = 3'd3,
    HZ_ISTALL   = 3'd4,
    HZ_FAULT    = 3'd5
  } hz_cause_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  // Held in reset: nothing loads, every stage register takes a bubble.
  localparam stage_ctrl_t CTRL_RESET = stage_ctrl_t'(9'b00000_1111);

  function automatic stage_ctrl_t ctrl_for(hz_cause_t cause);
    stage_ctrl_t c;
    c = stage_ctrl_t'(9'b11111_0000);
    case (cause)
      HZ_FAULT: c = stage_ctrl_t'(9'b00000_0000);
      HZ_DSTALL: begin
        c.pc_we       = 1'b0;
        c.ifid_we     = 1'b0;
        c.idex_we     = 1'b0;
        c.exmem_we    = 1'b0;
        c.memwb_flush = 1'b1;
      end
      HZ_REDIRECT: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      HZ_LOADUSE: begin
        c.pc_we      = 1'b0;
        c.ifid_we    = 1'b0;
        c.idex_flush = 1'b1;
      end
      HZ_ISTALL: begin
        c.pc_we      = 1'b0;
        c.ifid_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/loaduse_detect.sv
// Load-use hazard compare: the ID instruction reads the register a load in EX
// is about to write. x0 is hardwired and never creates a dependency.
module loaduse_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);

  always_comb begin
    hazard = ex_memread && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
              (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: priority-encodes the hazard cause, drives the
// stage enables, runs the dmem watchdog and keeps saturating perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output pctrl_state_t     dbg_state,
  output hz_cause_t        dbg_cause
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  pctrl_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              loaduse;
  logic              dstall;
  hz_cause_t         cause;
  stage_ctrl_t       ctrl;

  loaduse_detect u_loaduse (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .hazard      (loaduse)
  );

  // A pending dmem access masks every other hazard; they are re-seen on release.
  always_comb begin
    dstall = mem_req && !mem_ready;
    cause  = HZ_NONE;
    if (state == FAULT)       cause = HZ_FAULT;
    else if (dstall)          cause = HZ_DSTALL;
    else if (ex_branch_taken) cause = HZ_REDIRECT;
    else if (loaduse)         cause = HZ_LOADUSE;
    else if (!imem_ready)     cause = HZ_ISTALL;
    ctrl = reset ? CTRL_RESET : ctrl_for(cause);
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign mem_timeout = timeout_q && !reset;
  assign dbg_state   = state;
  assign dbg_cause   = cause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dstall) begin
            if (wait_cnt == WAIT_LAST) begin
              state     <= FAULT;
              timeout_q <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
          if ((cause inside {HZ_DSTALL, HZ_LOADUSE, HZ_ISTALL}) && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
          if ((cause == HZ_REDIRECT) && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
        default: begin
          state     <= FAULT;
          timeout_q <= 1'b1;
          wait_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. Each cycle it combines load-use hazards, taken-branch redirects, instruction-memory wait and data-memory wait into one set of write-enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also runs a data-memory watchdog that traps into a fault state, and keeps saturating stall and flush performance counters. It replaces ad-hoc per-hazard enables in the top level; operand forwarding stays a separate concern.

## Interface
- `MEM_TIMEOUT`, 255: consecutive dmem-stall cycles before fault (≥1).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads that source.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX.
- `imem_ready` in 1: fetch data is valid this cycle.
- `mem_req` in 1: the MEM stage holds a valid load or store.
- `mem_ready` in 1: dmem completes the MEM-stage access this cycle.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we` out 1: stage register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: load a bubble. Flush overrides we.
- `mem_timeout` out 1: high while in FAULT.
- `stall_cnt` out CNT_W: count of stall cycles.
- `flush_cnt` out CNT_W: count of branch flushes.

## Operation
- FSM states: RUN, FAULT.
- Reset (`reset`=1): state←RUN, wait_cnt←0, stall_cnt←0, flush_cnt←0.
- While `reset` is high, outputs are: all `*_we`=0, all `*_flush`=1, `mem_timeout`=0.
- Stage controls are combinational from the state and current inputs. The highest-priority matching case wins:
  1. **FAULT**: all we=0, all flush=0. The pipeline is frozen until reset.
  2. **dstall** (`mem_req && !mem_ready`): pc/ifid/idex/exmem we=0, memwb_flush=1. A branch or load-use present at the same time is ignored and re-evaluated after release.
  3. **redirect** (`ex_branch_taken`): all we=1, ifid_flush=1, idex_flush=1. This wins over load-use and istall; an unfinished fetch is abandoned.
  4. **loaduse** (`ex_memread && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))`): pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1, memwb_we=1. This wins over istall.
  5. **istall** (`!imem_ready`): pc_we=0, ifid_flush=1, all other we=1.
  6. **normal**: all we=1, all flush=0.
- Register x0 never causes a load-use stall.
- wait_cnt:
  - Increments on each cycle that dstall is active in RUN.
  - Clears on any cycle without dstall.
  - When wait_cnt==MEM_TIMEOUT−1 and dstall is active, the next state is FAULT.
- stall_cnt increments on cycles where dstall, loaduse or istall is the active case.
- flush_cnt increments on redirect cycles.
- Both counters saturate at all-ones and hold in FAULT.

## Timing
- Stage controls have zero latency: they respond combinationally in the same cycle as their inputs.
- The counters and `mem_timeout` are registered and update one edge after the event.
- Load-use inserts exactly one bubble. The following cycle, the load is in MEM and no longer matches.
- dstall releases in the same cycle `mem_ready` rises, and the pipeline advances at that edge.
- FAULT is entered after exactly MEM_TIMEOUT consecutive dstall cycles. `mem_timeout`=1 from the next cycle on.
- When reset is asserted mid-stall or in FAULT, the next cycle after deassertion is in RUN with the counters at 0.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum `pctrl_state_t` {RUN, FAULT};
  - the cause enum `hz_cause_t` {HZ_NONE, HZ_DSTALL, HZ_REDIRECT, HZ_LOADUSE, HZ_ISTALL, HZ_FAULT};
  - the control bundle struct `stage_ctrl_t` (5 we + 4 flush bits).
- Sub-module `loaduse_detect`: pure combinational hazard compare producing the loaduse condition.
- The top level contains the priority encoder, FSM, watchdog and counters.

## Test plan
- **Load-use:** ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; stall_cnt=1 next cycle. Repeating with ex_rd=0 gives normal controls.
- **Branch vs load-use:** ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_we=1; flush_cnt +1, stall_cnt unchanged.
- **Dmem stall:** mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1 → pc/ifid/idex/exmem we=0 and memwb_flush=1 for those 3 cycles; redirect applies in cycle 4, when mem_ready=1; stall_cnt=3.
- **Istall:** imem_ready=0 for 2 cycles → pc_we=0 and ifid_flush=1 for both cycles, idex/exmem/memwb we=1.
- **Watchdog:** with MEM_TIMEOUT=4, hold dstall for 4 cycles → FAULT; mem_timeout=1 from cycle 5 and all we=0. Asserting reset for 1 cycle returns to RUN with stall_cnt=0.
- **Saturation:** with CNT_W=3 and 9 istall cycles → stall_cnt holds at 7.
